// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and default sizing for the gondola lock controller
package lock_pkg;
  typedef enum logic [2:0] {
    CLOSED,
    OUTER_OPEN,
    INNER_OPEN,
    RAISING,
    LOWERING
  } state_t;
  localparam int OUTER_LEVEL_DEF = 0;
  localparam int INNER_LEVEL_DEF = 8;
  localparam int STEP_CYCLES_DEF = 4;
  localparam int LEVEL_W_DEF = 14;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/lock_controller_if.sv
// lock_controller_if: operator command inputs and lock status outputs
interface lock_controller_if #(
  parameter int LEVEL_W = lock_pkg::LEVEL_W_DEF,
  parameter int CNT_W = lock_pkg::CNT_W_DEF
);
  logic arrive;
  logic depart;
  logic outer_sw;
  logic inner_sw;
  logic raise_req;
  logic lower_req;
  logic [LEVEL_W-1:0] lock_level;
  logic outer_open;
  logic inner_open;
  logic occupied;
  logic [CNT_W-1:0] pass_count;
  logic err;
  modport master (
    output arrive, depart, outer_sw, inner_sw, raise_req, lower_req,
    input lock_level, outer_open, inner_open, occupied, pass_count, err
  );
  modport slave (
    input arrive, depart, outer_sw, inner_sw, raise_req, lower_req,
    output lock_level, outer_open, inner_open, occupied, pass_count, err
  );
endinterface

// File: rtl/lock_controller_edge_detect.sv
// edge_detect: rising-edge pulse of a level input against its registered history
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev;
  // remember last cycle's level so the pulse lasts exactly one cycle
  always_ff @(posedge clk)
    if (!rst) prev <= 1'b0;
    else prev <= d;
  assign rise = d & ~prev;
endmodule

// File: rtl/lock_controller.sv
// lock_controller: interlocked sequencing of the gondola lock ports, water level and passages
module lock_controller
  import lock_pkg::*;
#(
  parameter int OUTER_LEVEL = OUTER_LEVEL_DEF,
  parameter int INNER_LEVEL = INNER_LEVEL_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int LEVEL_W = LEVEL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  lock_controller_if.slave bus
);
  localparam int STEP_W = $clog2(STEP_CYCLES + 1);
  localparam logic [LEVEL_W-1:0] OUTER = LEVEL_W'(OUTER_LEVEL);
  localparam logic [LEVEL_W-1:0] INNER = LEVEL_W'(INNER_LEVEL);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEP_CYCLES - 1);
  state_t state, nxt;
  logic [LEVEL_W-1:0] level, level_nxt, up, dn;
  logic [STEP_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] pc, pc_nxt;
  logic occ, occ_nxt, err, err_nxt, outer_open, inner_open;
  logic [5:0] raw, rise;
  logic ra, rd, ro, ri, rr, rl;
  logic at_outer, at_inner, step_done, going, arr_ok, dep_ok, port_err, is_open;
  assign raw = {bus.arrive, bus.depart, bus.outer_sw, bus.inner_sw, bus.raise_req, bus.lower_req};
  for (genvar i = 0; i < 6; i++) begin : g_edge
    edge_detect u_edge (.clk(clk), .rst(rst), .d(raw[i]), .rise(rise[i]));
  end
  assign {ra, rd, ro, ri, rr, rl} = rise;
  assign at_outer = level == OUTER;
  assign at_inner = level == INNER;
  assign step_done = cnt == LAST;
  assign up = level + LEVEL_W'(1);
  assign dn = level - LEVEL_W'(1);
  assign is_open = state == OUTER_OPEN || state == INNER_OPEN;
  // state and every reported output are registered; reset abandons any ramp
  always_ff @(posedge clk)
    if (!rst) begin
      state <= CLOSED;
      level <= OUTER;
      cnt <= '0;
      occ <= 1'b0;
      pc <= '0;
      err <= 1'b0;
      outer_open <= 1'b0;
      inner_open <= 1'b0;
    end else begin
      state <= nxt;
      level <= level_nxt;
      cnt <= cnt_nxt;
      occ <= occ_nxt;
      pc <= pc_nxt;
      err <= err_nxt;
      outer_open <= nxt == OUTER_OPEN;
      inner_open <= nxt == INNER_OPEN;
    end
  // port and ramp interlocks; a ramp stops at the basin level or when its key is released or contradicted
  always_comb begin
    nxt = state;
    case (state)
      CLOSED:
        if (bus.outer_sw && bus.inner_sw) nxt = CLOSED;
        else if (bus.outer_sw) nxt = at_outer ? OUTER_OPEN : CLOSED;
        else if (bus.inner_sw) nxt = at_inner ? INNER_OPEN : CLOSED;
        else if (bus.raise_req && bus.lower_req) nxt = CLOSED;
        else if (bus.raise_req && level < INNER) nxt = RAISING;
        else if (bus.lower_req && level > OUTER) nxt = LOWERING;
      OUTER_OPEN: nxt = bus.outer_sw ? OUTER_OPEN : CLOSED;
      INNER_OPEN: nxt = bus.inner_sw ? INNER_OPEN : CLOSED;
      RAISING: nxt = (!bus.raise_req || bus.lower_req || (step_done && up == INNER)) ? CLOSED : RAISING;
      LOWERING: nxt = (!bus.lower_req || bus.raise_req || (step_done && dn == OUTER)) ? CLOSED : LOWERING;
      default: nxt = CLOSED;
    endcase
  end
  // level stepping, occupancy, passage count and the OR of all rejections this cycle
  always_comb begin
    going = (state == RAISING && bus.raise_req && !bus.lower_req) || (state == LOWERING && bus.lower_req && !bus.raise_req);
    cnt_nxt = (going && !step_done) ? cnt + STEP_W'(1) : '0;
    level_nxt = (going && step_done) ? (state == RAISING ? up : dn) : level;
    arr_ok = state == OUTER_OPEN && !occ;
    dep_ok = state == INNER_OPEN && occ;
    occ_nxt = (ra && arr_ok) ? 1'b1 : (rd && dep_ok) ? 1'b0 : occ;
    pc_nxt = (rd && dep_ok) ? pc + CNT_W'(1) : pc;
    port_err = state == CLOSED ? ((bus.outer_sw && bus.inner_sw && (ro || ri)) || (ro && !bus.inner_sw && !at_outer) || (ri && !bus.outer_sw && !at_inner)) : (state == RAISING || state == LOWERING) && (ro || ri);
    err_nxt = port_err || (is_open && (rr || rl)) || (ra && !arr_ok) || (rd && !dep_ok);
  end
  assign bus.lock_level = level;
  assign bus.outer_open = outer_open;
  assign bus.inner_open = inner_open;
  assign bus.occupied = occ;
  assign bus.pass_count = pc;
  assign bus.err = err;
endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed lock scenarios scored against hand-computed expected outputs
module tb_lock_controller;
  typedef struct packed {
    logic [13:0] level;
    logic oo;
    logic io;
    logic occ;
    logic [7:0] pc;
    logic err;
  } snap_t;
  typedef struct {
    int due;
    string name;
    snap_t exp;
  } item_t;
  logic clk = 0;
  logic rst = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  item_t q[$];
  lock_controller_if bus ();
  lock_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // queue what the outputs must show after the next edge, then advance to it
  task automatic chk(input string name, input int lvl, input logic oo, input logic io, input logic occ, input int pc, input logic e);
    item_t it;
    it.due = cyc + 1;
    it.name = name;
    it.exp = {14'(lvl), oo, io, occ, 8'(pc), e};
    q.push_back(it);
    tick();
  endtask
  // monitor: compare every due expectation against the registered outputs
  initial forever begin
    snap_t act;
    item_t it;
    @(negedge clk);
    act = {bus.lock_level, bus.outer_open, bus.inner_open, bus.occupied, bus.pass_count, bus.err};
    while (q.size() > 0 && q[0].due <= cyc) begin
      it = q.pop_front();
      n_chk++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got level=%0d outer=%b inner=%b occ=%b pass=%0d err=%b, want level=%0d outer=%b inner=%b occ=%b pass=%0d err=%b",
                 it.name, act.level, act.oo, act.io, act.occ, act.pc, act.err,
                 it.exp.level, it.exp.oo, it.exp.io, it.exp.occ, it.exp.pc, it.exp.err);
      end
    end
  end
  initial begin
    {bus.arrive, bus.depart, bus.outer_sw, bus.inner_sw, bus.raise_req, bus.lower_req} = '0;
    chk("reset0", 0, 0, 0, 0, 0, 0);
    chk("reset1", 0, 0, 0, 0, 0, 0);
    rst = 1;
    bus.outer_sw = 1;
    chk("outer_open", 0, 1, 0, 0, 0, 0);
    bus.arrive = 1;
    chk("arrive_ok", 0, 1, 0, 1, 0, 0);
    bus.arrive = 0;
    chk("arrive_low", 0, 1, 0, 1, 0, 0);
    bus.arrive = 1;
    chk("arrive_twice", 0, 1, 0, 1, 0, 1);
    bus.arrive = 0;
    chk("arrive_twice_end", 0, 1, 0, 1, 0, 0);
    bus.raise_req = 1;
    chk("raise_open_err", 0, 1, 0, 1, 0, 1);
    chk("raise_open_held", 0, 1, 0, 1, 0, 0);
    bus.raise_req = 0;
    bus.outer_sw = 0;
    chk("outer_close", 0, 0, 0, 1, 0, 0);
    bus.raise_req = 1;
    chk("raise_entry", 0, 0, 0, 1, 0, 0);
    for (int u = 1; u <= 8; u++) begin
      repeat (3) tick();
      chk($sformatf("raise_to_%0d", u), u, 0, 0, 1, 0, 0);
    end
    chk("raise_at_limit0", 8, 0, 0, 1, 0, 0);
    chk("raise_at_limit1", 8, 0, 0, 1, 0, 0);
    bus.raise_req = 0;
    bus.inner_sw = 1;
    chk("inner_open", 8, 0, 1, 1, 0, 0);
    bus.depart = 1;
    chk("depart_ok", 8, 0, 1, 0, 1, 0);
    bus.depart = 0;
    chk("depart_low", 8, 0, 1, 0, 1, 0);
    bus.depart = 1;
    chk("depart_empty", 8, 0, 1, 0, 1, 1);
    bus.depart = 0;
    chk("depart_empty_end", 8, 0, 1, 0, 1, 0);
    bus.inner_sw = 0;
    chk("inner_close", 8, 0, 0, 0, 1, 0);
    bus.lower_req = 1;
    chk("lower_entry", 8, 0, 0, 0, 1, 0);
    for (int u = 7; u >= 3; u--) begin
      repeat (3) tick();
      chk($sformatf("lower_to_%0d", u), u, 0, 0, 0, 1, 0);
    end
    bus.lower_req = 0;
    chk("lower_release", 3, 0, 0, 0, 1, 0);
    bus.raise_req = 1;
    chk("partial_entry", 3, 0, 0, 0, 1, 0);
    repeat (2) tick();
    bus.raise_req = 0;
    chk("partial_discard", 3, 0, 0, 0, 1, 0);
    bus.outer_sw = 1;
    chk("outer_wrong_level", 3, 0, 0, 0, 1, 1);
    chk("outer_wrong_held", 3, 0, 0, 0, 1, 0);
    bus.outer_sw = 0;
    bus.inner_sw = 1;
    chk("inner_wrong_level", 3, 0, 0, 0, 1, 1);
    bus.inner_sw = 0;
    chk("inner_wrong_end", 3, 0, 0, 0, 1, 0);
    bus.raise_req = 1;
    chk("ramp_entry", 3, 0, 0, 0, 1, 0);
    bus.outer_sw = 1;
    chk("port_during_ramp", 3, 0, 0, 0, 1, 1);
    bus.outer_sw = 0;
    chk("ramp_continue", 3, 0, 0, 0, 1, 0);
    tick();
    chk("ramp_step_4", 4, 0, 0, 0, 1, 0);
    bus.lower_req = 1;
    chk("both_keys_stop", 4, 0, 0, 0, 1, 0);
    bus.raise_req = 0;
    bus.lower_req = 0;
    chk("both_keys_idle", 4, 0, 0, 0, 1, 0);
    bus.lower_req = 1;
    chk("lower2_entry", 4, 0, 0, 0, 1, 0);
    for (int u = 3; u >= 0; u--) begin
      repeat (3) tick();
      chk($sformatf("lower2_to_%0d", u), u, 0, 0, 0, 1, 0);
    end
    bus.lower_req = 0;
    bus.outer_sw = 1;
    bus.inner_sw = 1;
    chk("both_ports", 0, 0, 0, 0, 1, 1);
    bus.outer_sw = 0;
    bus.inner_sw = 0;
    chk("both_ports_end", 0, 0, 0, 0, 1, 0);
    bus.arrive = 1;
    chk("arrive_closed", 0, 0, 0, 0, 1, 1);
    bus.arrive = 0;
    bus.outer_sw = 1;
    chk("outer_reopen", 0, 1, 0, 0, 1, 0);
    bus.arrive = 1;
    bus.depart = 1;
    chk("arrive_depart_same", 0, 1, 0, 1, 1, 1);
    bus.arrive = 0;
    bus.depart = 0;
    bus.outer_sw = 0;
    chk("outer_reclose", 0, 0, 0, 1, 1, 0);
    bus.raise_req = 1;
    chk("raise3_entry", 0, 0, 0, 1, 1, 0);
    for (int u = 1; u <= 5; u++) begin
      repeat (3) tick();
      chk($sformatf("raise3_to_%0d", u), u, 0, 0, 1, 1, 0);
    end
    tick();
    rst = 0;
    bus.raise_req = 0;
    chk("reset_mid_ramp", 0, 0, 0, 0, 0, 0);
    rst = 1;
    chk("after_reset", 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
